sys_cmd_ctrl: RTL

- Command controller sitting between the UART RX/TX byte interfaces and the system register file.
- Parses byte-framed commands from UART RX and issues single-cycle write or read strobes to the register file.
- Returns read data to UART TX.
- All outputs registered; one FSM, no buffering beyond one frame.

---
 rtl/sys_cmd_ctrl_pkg.sv | 24 ++
 rtl/sys_cmd_timeout.sv | 29 ++
 rtl/sys_cmd_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/sys_cmd_ctrl_pkg.sv
// Shared definitions for the UART command controller: FSM state encoding, default opcodes and widths.
// Latency: n/a (types and constants only). Backpressure: n/a.
package sys_cmd_ctrl_pkg;

  localparam int         WIDTH_DEF    = 8;
  localparam int         ADD_SIZE_DEF = 4;
  localparam logic [7:0] CMD_WR_DEF   = 8'hAA;
  localparam logic [7:0] CMD_RD_DEF   = 8'hBB;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  // States in which a partial frame is waiting for its next byte.
  function automatic logic is_timed(input state_t s);
    return (s == WR_ADDR) || (s == WR_DATA) || (s == RD_ADDR);
  endfunction

endpackage

// File: rtl/sys_cmd_timeout.sv
// Inter-byte timeout counter: counts while i_run, clears when idle or on i_clr, flags expiry at TIMEOUT_CYCLES-1.
// Latency: o_expired is combinational from the count register. Backpressure: none.
module sys_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_clr,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!i_run || i_clr) cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_expired = i_run && !i_clr && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/sys_cmd_ctrl.sv
// UART byte-command parser driving register-file read/write strobes; read data returned to UART TX.
// Latency: strobes 1 cycle after the last frame byte, o_tx_valid 2 cycles after o_rf_en_r. Backpressure: TX holds while i_tx_busy.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module sys_cmd_ctrl
  import sys_cmd_ctrl_pkg::*;
#(
  parameter int             WIDTH          = WIDTH_DEF,
  parameter int             ADD_SIZE       = ADD_SIZE_DEF,
  parameter logic [WIDTH-1:0] CMD_WR       = WIDTH'(CMD_WR_DEF),
  parameter logic [WIDTH-1:0] CMD_RD       = WIDTH'(CMD_RD_DEF),
  parameter int             TIMEOUT_CYCLES = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [WIDTH-1:0]    i_rx_data,
  input  logic                i_rx_valid,
  output logic [ADD_SIZE-1:0] o_rf_add,
  output logic [WIDTH-1:0]    o_rf_data,
  output logic                o_rf_en_w,
  output logic                o_rf_en_r,
  input  logic [WIDTH-1:0]    i_rf_data,
  output logic [WIDTH-1:0]    o_tx_data,
  output logic                o_tx_valid,
  input  logic                i_tx_busy,
  output logic                o_busy,
  output logic                o_err
);

  state_t              state_q, state_d;
  logic [ADD_SIZE-1:0] rf_add_q, rf_add_d;
  logic [WIDTH-1:0]    rf_data_q, rf_data_d;
  logic [WIDTH-1:0]    tx_data_q, tx_data_d;
  logic                en_w_q, en_w_d;
  logic                en_r_q, en_r_d;
  logic                tx_valid_q, tx_valid_d;
  logic                err_q, err_d;
  logic                cap_q, cap_d;
  logic                addr_ok;
  logic                timeout_expired;

  assign addr_ok = (i_rx_data[WIDTH-1:ADD_SIZE] == '0);

`ifdef CMD_TIMEOUT_EN
  sys_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_run     (is_timed(state_q)),
    .i_clr     (i_rx_valid),
    .o_expired (timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rf_add_d   = rf_add_q;
    rf_data_d  = rf_data_q;
    tx_data_d  = tx_data_q;
    en_w_d     = 1'b0;
    en_r_d     = 1'b0;
    tx_valid_d = 1'b0;
    err_d      = 1'b0;
    cap_d      = 1'b0;
    unique case (state_q)
      IDLE: if (i_rx_valid) begin
        if (i_rx_data == CMD_WR)      state_d = WR_ADDR;
        else if (i_rx_data == CMD_RD) state_d = RD_ADDR;
        else                          err_d   = 1'b1;
      end
      WR_ADDR: if (i_rx_valid) begin
        if (addr_ok) begin
          rf_add_d = i_rx_data[ADD_SIZE-1:0];
          state_d  = WR_DATA;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WR_DATA: if (i_rx_valid) begin
        rf_data_d = i_rx_data;
        en_w_d    = 1'b1;
        state_d   = IDLE;
      end
      RD_ADDR: if (i_rx_valid) begin
        if (addr_ok) begin
          rf_add_d = i_rx_data[ADD_SIZE-1:0];
          en_r_d   = 1'b1;
          state_d  = RD_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      // RD_WAIT spans the strobe cycle; the register file answers one cycle
      // later, so the capture lands on the first TX_SEND cycle (cap_q).
      RD_WAIT: begin
        err_d   = i_rx_valid;
        cap_d   = 1'b1;
        state_d = TX_SEND;
      end
      TX_SEND: begin
        err_d = i_rx_valid;
        if (cap_q) tx_data_d = i_rf_data;
        if (!i_tx_busy) begin
          tx_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (timeout_expired) begin
      err_d   = 1'b1;
      state_d = IDLE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= IDLE;
      rf_add_q   <= '0;
      rf_data_q  <= '0;
      tx_data_q  <= '0;
      en_w_q     <= 1'b0;
      en_r_q     <= 1'b0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      cap_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_add_q   <= rf_add_d;
      rf_data_q  <= rf_data_d;
      tx_data_q  <= tx_data_d;
      en_w_q     <= en_w_d;
      en_r_q     <= en_r_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      cap_q      <= cap_d;
    end
  end

  assign o_rf_add   = rf_add_q;
  assign o_rf_data  = rf_data_q;
  assign o_rf_en_w  = en_w_q;
  assign o_rf_en_r  = en_r_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_err      = err_q;
  assign o_busy     = (state_q != IDLE);

endmodule
